// File: rtl/tc_scan_scheduler.sv
// tc_scan_scheduler
//   Time-base scheduler and access arbiter for the timer/counter bank.
//   Each tick starts a sweep over all NUM_TC entries, one entry per clock.
//   Control-unit accesses take priority and stall the sweep for that cycle.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   tick         : time-base pulse, one clk wide
//   tcEnIn       : per-entry enable (timer) / count input (counter)
//   cpuEn/Op/Addr/Data : control-unit access (00 read, 01 preset, 10 clear acc, 11 type)
//   cpuRdData    : accumulator returned by a read, held until the next read
//   cpuAck       : access-complete pulse, one cycle after cpuEn
//   done         : per-entry done flags
//   busy         : high while a sweep is running
//   overrun      : sticky, a tick arrived while one was already pending
//
// Build option
//   TC_AUTORELOAD_EN : enabled timers that reach preset reload to 0 and
//                      flag done for that one sweep.
module tc_scan_scheduler #(
  parameter int NUM_TC = 8,
  parameter int ACC_W  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NUM_TC-1:0] tcEnIn,
  input  logic              cpuEn,
  input  logic [1:0]        cpuOp,
  input  logic [IDX_W-1:0]  cpuAddr,
  input  logic [ACC_W-1:0]  cpuData,
  output logic [ACC_W-1:0]  cpuRdData,
  output logic              cpuAck,
  output logic [NUM_TC-1:0] done,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                        state_q;
  logic [NUM_TC-1:0][ACC_W-1:0]  acc_q, preset_q;
  logic [NUM_TC-1:0]             type_q, en_q, latch_q, latch_d;
  logic [IDX_W-1:0]              idx_q;
  logic                          pend_q;

  logic             step, last;
  logic [ACC_W-1:0] cur_acc, cur_pre, acc_d;
  logic             done_d;

  // The scan only advances in cycles the control unit leaves the bank alone,
  // so a CPU write and a scan step can never hit the same entry together.
  assign step = (state_q == SCAN) && !cpuEn;
  assign last = (idx_q == IDX_W'(NUM_TC - 1));
  assign busy = (state_q == SCAN);

  // Update rule for the entry under the scan index.
  always_comb begin
    cur_acc = acc_q[idx_q];
    cur_pre = preset_q[idx_q];
    acc_d   = cur_acc;
    done_d  = 1'b0;
    if (!type_q[idx_q]) begin
      if (!tcEnIn[idx_q]) begin
        acc_d  = '0;
        done_d = 1'b0;
      end else begin
`ifdef TC_AUTORELOAD_EN
        if (cur_acc == cur_pre) begin
          acc_d  = '0;
          done_d = 1'b1;
        end else if (cur_acc < cur_pre) begin
          acc_d = cur_acc + ACC_W'(1);
        end
`else
        if (cur_acc < cur_pre) acc_d = cur_acc + ACC_W'(1);
        done_d = (acc_d == cur_pre);
`endif
      end
    end else begin
      if (latch_q[idx_q] && (cur_acc < cur_pre)) acc_d = cur_acc + ACC_W'(1);
      done_d = (acc_d == cur_pre);
    end
  end

  // Edge latches: consumed when their entry is scanned, but a new edge seen
  // in the same cycle is kept for the next sweep.
  always_comb begin
    latch_d = latch_q;
    if (step) latch_d[idx_q] = 1'b0;
    latch_d = latch_d | (tcEnIn & ~en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      preset_q  <= '0;
      type_q    <= '0;
      en_q      <= '0;
      latch_q   <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      done      <= '0;
      cpuRdData <= '0;
      cpuAck    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      en_q    <= tcEnIn;
      latch_q <= latch_d;
      cpuAck  <= cpuEn;

      if (cpuEn) begin
        case (cpuOp)
          2'b00: cpuRdData <= acc_q[cpuAddr];
          2'b01: preset_q[cpuAddr] <= cpuData;
          2'b10: begin
            acc_q[cpuAddr] <= '0;
            done[cpuAddr]  <= 1'b0;
          end
          default: type_q[cpuAddr] <= cpuData[0];
        endcase
      end

      case (state_q)
        IDLE: begin
          if (tick || pend_q) begin
            state_q <= SCAN;
            idx_q   <= '0;
            pend_q  <= 1'b0;
          end
        end
        default: begin
          // One tick may queue behind the running sweep; a second is dropped.
          if (tick) begin
            if (pend_q) overrun <= 1'b1;
            else        pend_q  <= 1'b1;
          end
          if (step) begin
            acc_q[idx_q] <= acc_d;
            done[idx_q]  <= done_d;
            if (last) begin
              idx_q <= '0;
              if (pend_q) pend_q  <= 1'b0;
              else        state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_scan_scheduler.sv
module tb_tc_scan_scheduler;
  localparam int N = 8, W = 8, IW = 3;

  logic          clk, reset, tick, cpuEn, cpuAck, busy, overrun;
  logic [N-1:0]  tcEnIn, done;
  logic [1:0]    cpuOp;
  logic [IW-1:0] cpuAddr;
  logic [W-1:0]  cpuData, cpuRdData;

  tc_scan_scheduler #(.NUM_TC(N), .ACC_W(W), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .tcEnIn(tcEnIn), .cpuEn(cpuEn),
    .cpuOp(cpuOp), .cpuAddr(cpuAddr), .cpuData(cpuData), .cpuRdData(cpuRdData),
    .cpuAck(cpuAck), .done(done), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sweep-level reference model
  int           m_acc[N], m_pre[N];
  bit           m_type[N], m_done[N], m_latch[N];
  logic [N-1:0] en_v;
  int           checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0; m_pre[i] = 0; m_type[i] = 0; m_done[i] = 0; m_latch[i] = 0;
    end
  endtask

  // One whole sweep applied to every entry, straight from the entry rules.
  task automatic m_sweep();
    for (int i = 0; i < N; i++) begin
      if (!m_type[i]) begin
        if (!en_v[i]) begin
          m_acc[i] = 0; m_done[i] = 0;
        end else begin
`ifdef TC_AUTORELOAD_EN
          if (m_acc[i] == m_pre[i]) begin m_acc[i] = 0; m_done[i] = 1; end
          else begin
            if (m_acc[i] < m_pre[i]) m_acc[i] = m_acc[i] + 1;
            m_done[i] = 0;
          end
`else
          if (m_acc[i] < m_pre[i]) m_acc[i] = m_acc[i] + 1;
          m_done[i] = (m_acc[i] == m_pre[i]);
`endif
        end
      end else begin
        if (m_latch[i] && m_acc[i] < m_pre[i]) m_acc[i] = m_acc[i] + 1;
        m_done[i] = (m_acc[i] == m_pre[i]);
      end
      m_latch[i] = 0;
    end
  endtask

  task automatic set_en(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i] && !en_v[i]) m_latch[i] = 1;
    en_v = v; tcEnIn = v;
    step(); step();
  endtask

  task automatic cpu(input logic [1:0] op, input int addr, input int data);
    cpuEn = 1; cpuOp = op; cpuAddr = IW'(addr); cpuData = W'(data);
    step();
    cpuEn = 0;
    chk("cpu_ack", cpuAck, 1);
    case (op)
      2'b00: chk("cpu_rd", cpuRdData, m_acc[addr]);
      2'b01: m_pre[addr] = data;
      2'b10: begin m_acc[addr] = 0; m_done[addr] = 0; end
      default: m_type[addr] = data[0];
    endcase
    step();
    chk("cpu_ack_drop", cpuAck, 0);
  endtask

  task automatic sweep(output int cyc);
    tick = 1; step(); tick = 0;
    cyc = 0;
    while (busy && cyc < 200) begin cyc++; step(); end
    if (cyc >= 200) chk("sweep_timeout", 1, 0);
    m_sweep();
  endtask

  task automatic check_done();
    logic [N-1:0] dv;
    for (int i = 0; i < N; i++) dv[i] = m_done[i];
    chk("done_vec", done, dv);
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) cpu(2'b00, i, 0);
    check_done();
  endtask

  initial begin
    int c;
    reset = 1; tick = 0; cpuEn = 0; cpuOp = 0; cpuAddr = 0; cpuData = 0;
    tcEnIn = 0; en_v = 0;
    m_reset();
    step(); step();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", cpuAck, 0);
    chk("rst_rd", cpuRdData, 0);
    check_all();

    // Timer: entry 2, preset 3, enable held over 4 sweeps
    cpu(2'b01, 2, 3);
    set_en(8'b0000_0100);
    for (int k = 0; k < 4; k++) begin
      sweep(c);
      chk("sweep_len", c, N);
      cpu(2'b00, 2, 0);
      check_done();
`ifndef TC_AUTORELOAD_EN
      chk("timer_acc_seq", cpuRdData, (k < 3) ? k + 1 : 3);
      chk("timer_done_seq", done[2], (k >= 2) ? 1 : 0);
`else
      chk("timer_acc_seq", cpuRdData, (k + 1) % 4);
      chk("timer_done_seq", done[2], (k == 3) ? 1 : 0);
`endif
    end

    // Counter: entry 5 preset 2, two pulses; entry 6 counter with preset 0
    cpu(2'b11, 5, 1);
    cpu(2'b01, 5, 2);
    cpu(2'b11, 6, 1);
    for (int k = 0; k < 2; k++) begin
      set_en(en_v | 8'b0010_0000);
      set_en(en_v & 8'b1101_1111);
      sweep(c);
    end
    cpu(2'b00, 5, 0);
    chk("ctr_acc2", cpuRdData, 2);
    chk("ctr_done5", done[5], 1);
    chk("ctr_preset0_done", done[6], 1);
    cpu(2'b10, 5, 0);
    cpu(2'b01, 5, 5);
    set_en(en_v | 8'b0010_0000);
    for (int k = 0; k < 3; k++) sweep(c);
    cpu(2'b00, 5, 0);
    chk("ctr_held_one", cpuRdData, 1);
    check_all();

    // Arbitration: reads of entry 4 stall the sweep for 3 cycles
    cpu(2'b01, 4, 4);
    set_en(en_v | 8'b0001_0000);
    sweep(c);
    tick = 1; step(); tick = 0;
    c = 0;
    while (busy && c < 200) begin
      c++;
      if (c >= 2 && c <= 4) begin cpuEn = 1; cpuOp = 2'b00; cpuAddr = 3'd4; end
      else cpuEn = 0;
      step();
      if (c >= 2 && c <= 4) begin
        chk("arb_ack", cpuAck, 1);
        chk("arb_rd", cpuRdData, m_acc[4]);
      end
      if (c == 5) chk("arb_ack_drop", cpuAck, 0);
    end
    cpuEn = 0;
    chk("arb_busy_len", c, N + 3);
    m_sweep();
    check_all();

    // Overrun: two extra ticks inside one sweep
    tick = 1; step(); tick = 0;
    c = 0;
    while (busy && c < 200) begin
      c++;
      tick = (c == 2 || c == 4);
      step();
      tick = 0;
      if (c == 2) chk("ovr_not_yet", overrun, 0);
      if (c == 4) chk("ovr_set", overrun, 1);
    end
    chk("ovr_busy_len", c, 2 * N);
    m_sweep(); m_sweep();
    check_all();

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      set_en(N'($urandom));
      if ($urandom_range(0, 1) == 1) cpu(2'b01, $urandom_range(0, N-1), $urandom_range(1, 5));
      if ($urandom_range(0, 3) == 0) cpu(2'b10, $urandom_range(0, N-1), 0);
      if ($urandom_range(0, 3) == 0) cpu(2'b11, $urandom_range(0, N-1), $urandom_range(0, 1));
      sweep(c);
      chk("rnd_sweep_len", c, N);
      check_all();
    end
    chk("ovr_sticky", overrun, 1);

    // Reset mid-sweep at index 3
    tick = 1; step(); tick = 0;
    step(); step(); step();
    chk("mid_busy", busy, 1);
    reset = 1; tcEnIn = 0; en_v = 0;
    step();
    reset = 0;
    m_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_done", done, 0);
    check_all();
    sweep(c);
    chk("post_rst_sweep_len", c, N);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
